pc_stack_unit: RTL and testbench

- Parametrised program-counter unit. Successor to the fixed 16-bit PC register.
- Adds configurable width, reset vector and increment step, a stall input, and an internal return-address stack (RAS) for call/return.
- Sits between the write/read decoders (which supply one-bit strobes) and instruction fetch. Loads from the A bus, clears, increments, calls and returns.

---
 rtl/pc_stack_unit_pkg.sv | 32 +++
 rtl/pc_stack_unit_if.sv | 37 +++
 rtl/pc_stack_unit_ras_lifo.sv | 45 ++++
 rtl/pc_stack_unit.sv | 85 ++++++++
 tb/tb_pc_stack_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the PC / return-address-stack unit.
//   act_t / ACT_*  : one-hot-free action code chosen each cycle
//   pc_prio()      : fixed-priority strobe encoder (clr > ret > call > ld > inc)
//   sp_width()     : stack-pointer width able to hold 0..DEPTH
package pc_stack_unit_pkg;

    typedef logic [2:0] act_t;

    localparam act_t ACT_NONE = 3'd0;
    localparam act_t ACT_CLR  = 3'd1;
    localparam act_t ACT_RET  = 3'd2;
    localparam act_t ACT_CALL = 3'd3;
    localparam act_t ACT_LD   = 3'd4;
    localparam act_t ACT_INC  = 3'd5;

    function automatic act_t pc_prio(input logic clr, input logic ret,
                                     input logic call, input logic ld,
                                     input logic inc);
        if (clr)       return ACT_CLR;
        else if (ret)  return ACT_RET;
        else if (call) return ACT_CALL;
        else if (ld)   return ACT_LD;
        else if (inc)  return ACT_INC;
        else           return ACT_NONE;
    endfunction

    // One extra bit so a full stack (sp == DEPTH) is representable.
    function automatic int sp_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Strobe/status bundle between the decoders, the PC unit and fetch.
//   slave  : the PC unit (takes strobes + A bus, drives PC and stack status)
//   master : the decoder/fetch side
interface pc_stack_unit_if
    import pc_stack_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int SPW = sp_width(DEPTH);

    logic [WIDTH-1:0] A_BUS_out;
    logic             ld;
    logic             clr;
    logic             inc;
    logic             call;
    logic             ret;
    logic             stall;
    logic             flag_clr;
    logic [WIDTH-1:0] PC_out;
    logic [SPW-1:0]   sp_out;
    logic             stk_empty;
    logic             stk_full;
    logic             ovf;
    logic             unf;

    modport slave (
        input  A_BUS_out, ld, clr, inc, call, ret, stall, flag_clr,
        output PC_out, sp_out, stk_empty, stk_full, ovf, unf
    );

    modport master (
        output A_BUS_out, ld, clr, inc, call, ret, stall, flag_clr,
        input  PC_out, sp_out, stk_empty, stk_full, ovf, unf
    );

endinterface

// File: rtl/pc_stack_unit_ras_lifo.sv
// Return-address LIFO.
//   Clock, Reset_n : clock / async active-low reset (clears sp only)
//   push, din      : write din at sp, sp+1 (caller guarantees !full)
//   pop            : sp-1 (caller guarantees !empty); never with push
//   dout           : entry at sp-1 (garbage when empty)
//   sp, full, empty: occupancy 0..DEPTH and its decodes
module ras_lifo
    import pc_stack_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int SPW  = sp_width(DEPTH),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;

    // DEPTH is a power of two, so the low AW bits address the slot directly.
    assign top_idx = sp[AW-1:0] - AW'(1);
    assign dout    = mem[top_idx];
    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)  sp <= '0;
        else if (push) sp <= sp + SPW'(1);
        else if (pop)  sp <= sp - SPW'(1);
    end

    // Contents need no reset; only sp defines what is valid.
    always_ff @(posedge Clock) begin
        if (push) mem[sp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Parametrised program counter with return-address stack.
//   Clock, Reset_n : clock / async active-low reset
//   bus (slave)    : strobes clr/ret/call/ld/inc, stall, flag_clr, A_BUS_out in;
//                    PC_out, sp_out, stk_empty, stk_full, ovf, unf out
// One action per unstalled cycle, priority clr > ret > call > ld > inc.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] INC_STEP  = WIDTH'(1)
) (
    input logic            Clock,
    input logic            Reset_n,
    pc_stack_unit_if.slave bus
);
    localparam int SPW = sp_width(DEPTH);

    act_t             act;
    logic [WIDTH-1:0] pc_q, pc_d, pc_next_seq, ras_top;
    logic [SPW-1:0]   sp;
    logic             full, empty, push, pop;
    logic             ovf_q, unf_q, set_ovf, set_unf;

    assign act         = pc_prio(bus.clr, bus.ret, bus.call, bus.ld, bus.inc);
    assign pc_next_seq = pc_q + INC_STEP;   // wraps mod 2^WIDTH

    // Stack operations are gated here so a stalled or overflowing call never
    // disturbs the LIFO.
    assign push    = !bus.stall && (act == ACT_CALL) && !full;
    assign pop     = !bus.stall && (act == ACT_RET)  && !empty;
    assign set_ovf = (act == ACT_CALL) && full;
    assign set_unf = (act == ACT_RET)  && empty;

    always_comb begin
        pc_d = pc_q;
        unique case (act)
            ACT_CLR:  pc_d = RESET_VEC;
            ACT_RET:  if (!empty) pc_d = ras_top;
            ACT_CALL: if (!full)  pc_d = bus.A_BUS_out;
            ACT_LD:   pc_d = bus.A_BUS_out;
            ACT_INC:  pc_d = pc_next_seq;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)        pc_q <= RESET_VEC;
        else if (!bus.stall) pc_q <= pc_d;
    end

    // Sticky flags: a set in the same cycle beats flag_clr.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.stall) begin
            if (set_ovf)           ovf_q <= 1'b1;
            else if (bus.flag_clr) ovf_q <= 1'b0;
            if (set_unf)           unf_q <= 1'b1;
            else if (bus.flag_clr) unf_q <= 1'b0;
        end
    end

    ras_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .push    (push),
        .pop     (pop),
        .din     (pc_next_seq),
        .dout    (ras_top),
        .sp      (sp),
        .full    (full),
        .empty   (empty)
    );

    assign bus.PC_out    = pc_q;
    assign bus.sp_out    = sp;
    assign bus.stk_empty = empty;
    assign bus.stk_full  = full;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;
    logic Clock;
    logic Reset_n;
    int   checks;
    int   errors;

    pc_stack_unit_if #(.WIDTH(16), .DEPTH(8)) bus ();

    pc_stack_unit #(
        .WIDTH(16), .DEPTH(8), .RESET_VEC(16'h0000), .INC_STEP(16'h0001)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic idle();
        bus.A_BUS_out = '0;
        bus.ld = 0; bus.clr = 0; bus.inc = 0; bus.call = 0;
        bus.ret = 0; bus.stall = 0; bus.flag_clr = 0;
    endtask

    // Advance one edge, sample 1 time unit after it, drop strobes.
    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic do_ld(input logic [15:0] a);
        bus.ld = 1; bus.A_BUS_out = a; tick();
    endtask

    task automatic do_call(input logic [15:0] a);
        bus.call = 1; bus.A_BUS_out = a; tick();
    endtask

    task automatic test_reset();
        idle();
        Reset_n = 0;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (bus.PC_out !== 16'h0000) begin errors++; $display("FAIL reset_pc PC_out=%h expected 0000", bus.PC_out); end
        checks++; if (bus.sp_out !== 4'd0) begin errors++; $display("FAIL reset_sp sp_out=%0d expected 0", bus.sp_out); end
        checks++; if ({bus.stk_empty, bus.stk_full, bus.ovf, bus.unf} !== 4'b1000) begin errors++; $display("FAIL reset_flags empty/full/ovf/unf=%b expected 1000", {bus.stk_empty, bus.stk_full, bus.ovf, bus.unf}); end
        @(negedge Clock);
        Reset_n = 1;
        tick();
        checks++; if (bus.PC_out !== 16'h0000) begin errors++; $display("FAIL reset_idle PC_out=%h expected 0000", bus.PC_out); end
    endtask

    task automatic test_inc();
        for (int i = 1; i <= 3; i++) begin
            bus.inc = 1; tick();
            checks++; if (bus.PC_out !== 16'(i)) begin errors++; $display("FAIL inc_%0d PC_out=%h expected %h", i, bus.PC_out, 16'(i)); end
        end
    endtask

    task automatic test_async_reset();
        do_call(16'h0020);
        checks++; if (bus.sp_out !== 4'd1) begin errors++; $display("FAIL pre_rst_sp sp_out=%0d expected 1", bus.sp_out); end
        #2;
        Reset_n = 0;
        #1;
        checks++; if (bus.PC_out !== 16'h0000) begin errors++; $display("FAIL async_rst_pc PC_out=%h expected 0000", bus.PC_out); end
        checks++; if (bus.sp_out !== 4'd0) begin errors++; $display("FAIL async_rst_sp sp_out=%0d expected 0", bus.sp_out); end
        @(negedge Clock);
        Reset_n = 1;
        tick();
    endtask

    task automatic test_wrap_ld();
        do_ld(16'hFFFF);
        checks++; if (bus.PC_out !== 16'hFFFF) begin errors++; $display("FAIL ld_ffff PC_out=%h expected ffff", bus.PC_out); end
        bus.inc = 1; tick();
        checks++; if (bus.PC_out !== 16'h0000) begin errors++; $display("FAIL inc_wrap PC_out=%h expected 0000", bus.PC_out); end
        bus.ld = 1; bus.inc = 1; bus.A_BUS_out = 16'h1234; tick();
        checks++; if (bus.PC_out !== 16'h1234) begin errors++; $display("FAIL ld_over_inc PC_out=%h expected 1234", bus.PC_out); end
    endtask

    task automatic test_call_ret();
        do_ld(16'h0010);
        do_call(16'h0200);
        checks++; if (bus.PC_out !== 16'h0200) begin errors++; $display("FAIL call_pc PC_out=%h expected 0200", bus.PC_out); end
        checks++; if (bus.sp_out !== 4'd1 || bus.stk_empty !== 1'b0) begin errors++; $display("FAIL call_sp sp_out=%0d empty=%b expected 1/0", bus.sp_out, bus.stk_empty); end
        bus.inc = 1; tick();
        bus.inc = 1; tick();
        checks++; if (bus.PC_out !== 16'h0202) begin errors++; $display("FAIL callee_inc PC_out=%h expected 0202", bus.PC_out); end
        bus.ret = 1; tick();
        checks++; if (bus.PC_out !== 16'h0011) begin errors++; $display("FAIL ret_pc PC_out=%h expected 0011", bus.PC_out); end
        checks++; if (bus.sp_out !== 4'd0 || bus.stk_empty !== 1'b1) begin errors++; $display("FAIL ret_sp sp_out=%0d empty=%b expected 0/1", bus.sp_out, bus.stk_empty); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_ra;
        do_ld(16'h0100);
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.stk_full !== 1'b0) begin errors++; $display("FAIL full_early_%0d stk_full=%b expected 0", i, bus.stk_full); end
            do_call(16'h1000 + 16'(i));
        end
        checks++; if (bus.stk_full !== 1'b1 || bus.sp_out !== 4'd8) begin errors++; $display("FAIL full_8 stk_full=%b sp_out=%0d expected 1/8", bus.stk_full, bus.sp_out); end
        do_call(16'h0500);
        checks++; if (bus.PC_out !== 16'h1007) begin errors++; $display("FAIL ovf_pc PC_out=%h expected 1007", bus.PC_out); end
        checks++; if (bus.sp_out !== 4'd8 || bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag sp_out=%0d ovf=%b expected 8/1", bus.sp_out, bus.ovf); end
        bus.flag_clr = 1; tick();
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr ovf=%b expected 0", bus.ovf); end
        // Drain: call k (k>=1) was made from 0x1000+k-1, call 0 from 0x0100.
        for (int k = 7; k >= 0; k--) begin
            exp_ra = (k == 0) ? 16'h0101 : 16'h1000 + 16'(k);
            bus.ret = 1; tick();
            checks++; if (bus.PC_out !== exp_ra || bus.sp_out !== 4'(k)) begin errors++; $display("FAIL drain_%0d PC_out=%h sp_out=%0d expected %h/%0d", k, bus.PC_out, bus.sp_out, exp_ra, k); end
        end
    endtask

    task automatic test_underflow();
        bus.ret = 1; tick();
        checks++; if (bus.PC_out !== 16'h0101 || bus.unf !== 1'b1) begin errors++; $display("FAIL unf_set PC_out=%h unf=%b expected 0101/1", bus.PC_out, bus.unf); end
        bus.ret = 1; bus.flag_clr = 1; tick();
        checks++; if (bus.unf !== 1'b1 || bus.sp_out !== 4'd0) begin errors++; $display("FAIL unf_set_wins unf=%b sp_out=%0d expected 1/0", bus.unf, bus.sp_out); end
        bus.flag_clr = 1; tick();
        checks++; if (bus.unf !== 1'b0) begin errors++; $display("FAIL unf_clr unf=%b expected 0", bus.unf); end
    endtask

    task automatic test_stall();
        bus.ret = 1; tick();                 // unf=1 again
        do_call(16'h0300);                   // pushes 0x0102, sp=1
        checks++; if (bus.PC_out !== 16'h0300 || bus.sp_out !== 4'd1) begin errors++; $display("FAIL stall_setup PC_out=%h sp_out=%0d expected 0300/1", bus.PC_out, bus.sp_out); end
        bus.stall = 1; bus.clr = 1; bus.call = 1; bus.inc = 1; bus.flag_clr = 1;
        bus.A_BUS_out = 16'h0999; tick();
        checks++; if (bus.PC_out !== 16'h0300 || bus.sp_out !== 4'd1) begin errors++; $display("FAIL stall_hold PC_out=%h sp_out=%0d expected 0300/1", bus.PC_out, bus.sp_out); end
        checks++; if (bus.unf !== 1'b1 || bus.ovf !== 1'b0) begin errors++; $display("FAIL stall_flags unf=%b ovf=%b expected 1/0", bus.unf, bus.ovf); end
        bus.clr = 1; bus.ret = 1; tick();
        checks++; if (bus.PC_out !== 16'h0000 || bus.sp_out !== 4'd1) begin errors++; $display("FAIL clr_over_ret PC_out=%h sp_out=%0d expected 0000/1", bus.PC_out, bus.sp_out); end
        bus.ret = 1; bus.call = 1; bus.A_BUS_out = 16'h0777; tick();
        checks++; if (bus.PC_out !== 16'h0102 || bus.sp_out !== 4'd0) begin errors++; $display("FAIL ret_over_call PC_out=%h sp_out=%0d expected 0102/0", bus.PC_out, bus.sp_out); end
        bus.flag_clr = 1; tick();
    endtask

    task automatic test_back_to_back();
        do_ld(16'h0040);
        do_call(16'h0080);
        checks++; if (bus.PC_out !== 16'h0080) begin errors++; $display("FAIL b2b_call PC_out=%h expected 0080", bus.PC_out); end
        bus.ret = 1; tick();
        checks++; if (bus.PC_out !== 16'h0041 || bus.stk_empty !== 1'b1) begin errors++; $display("FAIL b2b_ret PC_out=%h empty=%b expected 0041/1", bus.PC_out, bus.stk_empty); end
        bus.call = 1; bus.ld = 1; bus.A_BUS_out = 16'h00C0; tick();
        checks++; if (bus.PC_out !== 16'h00C0 || bus.sp_out !== 4'd1) begin errors++; $display("FAIL call_over_ld PC_out=%h sp_out=%0d expected 00c0/1", bus.PC_out, bus.sp_out); end
        bus.ret = 1; tick();
        checks++; if (bus.PC_out !== 16'h0042) begin errors++; $display("FAIL b2b_ret2 PC_out=%h expected 0042", bus.PC_out); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset_n = 1;
        idle();
        test_reset();
        test_inc();
        test_async_reset();
        test_wrap_ld();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
